// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types and helpers for the AES round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Datapath round flavour selected by the sequencer
  typedef enum logic [1:0] {
    RND_INIT  = 2'b00,  // initial AddRoundKey only
    RND_FULL  = 2'b01,  // full (inverse) round
    RND_FINAL = 2'b10   // last round, no (Inv)MixColumns
  } rnd_sel_t;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } ctrl_state_t;

  // Round count for a given key length (10/12/14)
  function automatic int nr_of(input int k);
    return k / 32 + 6;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_cnt.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_cnt
// Purpose  : 4-bit loadable up/down round-key counter. The flags report
//            whether the next step lands exactly on NR or on 0, so the
//            sequencer can leave a phase on the cycle that produces the
//            boundary value. The count saturates instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_cnt #(
  parameter int NR = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  input  logic       i_dn,
  output logic [3:0] o_cnt,
  output logic       o_at_zero,
  output logic       o_at_nr
);

  localparam logic [3:0] c_NR = 4'(NR);

  logic [3:0] r_cnt;
  logic [3:0] w_step;
  logic       w_edge;

  assign w_step    = i_dn ? (r_cnt - 4'd1) : (r_cnt + 4'd1);
  // A step past either end of the 4-bit range is blocked
  assign w_edge    = i_dn ? (r_cnt == 4'd0) : (r_cnt == 4'hF);
  assign o_at_zero = !w_edge && (w_step == 4'd0);
  assign o_at_nr   = !w_edge && (w_step == c_NR);
  assign o_cnt     = r_cnt;

  // Counter register: load has priority over stepping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !w_edge) begin
      r_cnt <= w_step;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Round sequencer for the iterative AES enc/dec core. Issues
//            key-schedule, state-register and round-select controls for NR
//            rounds and pulses done when the result is ready.
//            Optional build macro AES_KEY_CACHE_EN adds the key_new input and
//            skips key reload / forward expansion when the key is reusable.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int K = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       decrypt,
`ifdef AES_KEY_CACHE_EN
  input  logic       key_new,
`endif
  output logic       busy,
  output logic       done,
  output logic       key_load,
  output logic       key_step,
  output logic       key_rev,
  output logic [3:0] rk_idx,
  output logic       st_en,
  output logic [1:0] rnd_sel,
  output logic       inv
);

  localparam int         NR   = nr_of(K);
  localparam logic [3:0] c_NR = 4'(NR);

  if (K != 128 && K != 192 && K != 256) begin : g_bad_k
    $error("aes_round_ctrl: K must be 128, 192 or 256");
  end

  ctrl_state_t r_state, w_state_nxt;
  rnd_sel_t    r_rnd_sel;
  logic        r_busy, r_done, r_key_step, r_key_rev, r_st_en, r_inv;
  logic        w_accept, w_skip, w_key_load, w_inv_nxt;
  logic        w_cnt_load, w_cnt_en, w_cnt_dn, w_at_zero, w_at_nr;
  logic [3:0]  w_cnt, w_cnt_val;

  assign w_accept  = (r_state == IDLE) && start && reset;
  assign w_inv_nxt = w_accept ? decrypt : r_inv;
  // Forward expansion during KEYEXP, otherwise the direction of the cipher
  assign w_cnt_dn  = r_inv && (r_state != KEYEXP);

`ifdef AES_KEY_CACHE_EN
  logic r_cache_valid;

  // A decrypt can reuse the expanded last round key left by an encrypt
  assign w_skip     = decrypt && !key_new && r_cache_valid && (w_cnt == c_NR);
  assign w_key_load = w_accept && (!decrypt || key_new || !r_cache_valid);

  // Key register holds a usable key once any operation has completed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cache_valid <= 1'b0;
    end else if (r_state == DONE) begin
      r_cache_valid <= 1'b1;
    end
  end
`else
  assign w_skip     = 1'b0;
  assign w_key_load = w_accept;
`endif

  aes_round_cnt #(.NR(NR)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .i_dn       (w_cnt_dn),
    .o_cnt      (w_cnt),
    .o_at_zero  (w_at_zero),
    .o_at_nr    (w_at_nr)
  );

  // Next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = 4'd0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_load  = 1'b1;
          w_cnt_val   = w_skip ? c_NR : 4'd0;
          w_state_nxt = (decrypt && !w_skip) ? KEYEXP : INIT;
        end
      end
      KEYEXP: begin
        w_cnt_en = 1'b1;
        if (w_at_nr) w_state_nxt = INIT;
      end
      INIT: begin
        w_cnt_en    = 1'b1;
        w_state_nxt = ROUND;
      end
      ROUND: begin
        w_cnt_en = 1'b1;
        if (r_inv ? w_at_zero : w_at_nr) w_state_nxt = FINAL;
      end
      FINAL:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state (Moore, registered)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_key_step <= 1'b0;
      r_key_rev  <= 1'b0;
      r_st_en    <= 1'b0;
      r_rnd_sel  <= RND_INIT;
      r_inv      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inv      <= w_inv_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      r_key_step <= (w_state_nxt == KEYEXP) || (w_state_nxt == INIT) ||
                    (w_state_nxt == ROUND);
      r_key_rev  <= w_inv_nxt && ((w_state_nxt == INIT) || (w_state_nxt == ROUND));
      r_st_en    <= (w_state_nxt == INIT) || (w_state_nxt == ROUND) ||
                    (w_state_nxt == FINAL);
      r_rnd_sel  <= (w_state_nxt == ROUND) ? RND_FULL :
                    (w_state_nxt == FINAL) ? RND_FINAL : RND_INIT;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign key_load = w_key_load;
  assign key_step = r_key_step;
  assign key_rev  = r_key_rev;
  assign rk_idx   = w_cnt;
  assign st_en    = r_st_en;
  assign rnd_sel  = r_rnd_sel;
  assign inv      = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Scoreboard bench for aes_round_ctrl with K = 128/192/256
//            instances. Honours AES_KEY_CACHE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  localparam int NI = 3;
  localparam int NR_TAB [NI] = '{10, 12, 14};

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] start, decrypt;
`ifdef AES_KEY_CACHE_EN
  logic [NI-1:0] key_new;
`endif
  logic [NI-1:0] busy, done, key_load, key_step, key_rev, st_en, inv;
  logic [3:0]    rk_idx  [NI];
  logic [1:0]    rnd_sel [NI];

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int t_acc;
    int t_done;
    bit inv;
    bit kl;
    int len;
  } exp_t;

  exp_t        exp_q [NI][$];
  logic [10:0] rec_q [NI][$];
  bit          cv_m   [NI];
  int          kpos_m [NI];

  always #5 clk = ~clk;

  // Cycle index, advanced on every active edge
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_round_ctrl #(.K(128 + 64 * g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .decrypt  (decrypt[g]),
`ifdef AES_KEY_CACHE_EN
      .key_new  (key_new[g]),
`endif
      .busy     (busy[g]),
      .done     (done[g]),
      .key_load (key_load[g]),
      .key_step (key_step[g]),
      .key_rev  (key_rev[g]),
      .rk_idx   (rk_idx[g]),
      .st_en    (st_en[g]),
      .rnd_sel  (rnd_sel[g]),
      .inv      (inv[g])
    );

    logic [10:0] col [$];
    int          kl_n = 0;
    int          kl_c = -1;
    exp_t        e;
    int          bad;
    logic [10:0] got_r, want_r;

    // Monitor: collect per-cycle controls while busy, score on done
    always @(negedge clk) begin
      if (!reset) begin
        col.delete();
        kl_n = 0;
        kl_c = -1;
        exp_q[g].delete();
        rec_q[g].delete();
      end else begin
        if (key_load[g]) begin
          kl_n++;
          kl_c = cyc;
        end
        if (busy[g])
          col.push_back({busy[g], done[g], key_step[g], key_rev[g] & key_step[g],
                         st_en[g], rnd_sel[g] & {2{st_en[g]}}, rk_idx[g]});
        if (done[g]) begin
          if (exp_q[g].size() == 0) begin
            n_total++;
            $display("FAIL inst%0d unexpected_done: got done at cycle %0d, required none", g, cyc);
          end else begin
            e = exp_q[g].pop_front();
            check(g, "done_cycle", cyc, e.t_done);
            check(g, "inv", int'(inv[g]), int'(e.inv));
            check(g, "key_load_count", kl_n, e.kl ? 1 : 0);
            if (e.kl) check(g, "key_load_cycle", kl_c, e.t_acc);
            bad    = -1;
            got_r  = '0;
            want_r = '0;
            for (int k = 0; k < e.len; k++) begin
              want_r = rec_q[g].pop_front();
              if (bad < 0 && (k >= col.size() || col[k] !== want_r)) begin
                bad   = k;
                got_r = (k < col.size()) ? col[k] : 11'h7FF;
              end
            end
            if (bad < 0 && col.size() != e.len) bad = e.len;
            n_total++;
            if (bad < 0) n_pass++;
            else $display("FAIL inst%0d trace: record %0d got %h required %h (records got %0d required %0d)",
                          g, bad, got_r, want_r, col.size(), e.len);
          end
          col.delete();
          kl_n = 0;
          kl_c = -1;
        end
      end
    end
  end

  task automatic check(input int inst, input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL inst%0d %s: got %0d required %0d", inst, name, got, want);
  endtask

  // {busy, done, key_step, key_rev, st_en, rnd_sel, rk_idx}
  function automatic logic [10:0] mk(input bit dn, input bit ks, input bit kr,
                                     input bit se, input logic [1:0] rs, input int rk);
    return {1'b1, dn, ks, kr, se, rs, 4'(rk)};
  endfunction

  function automatic int outs(input int g);
    return int'({busy[g], done[g], key_load[g], key_step[g], key_rev[g],
                 st_en[g], inv[g], rk_idx[g], rnd_sel[g]});
  endfunction

  // Expected response for a request accepted at cycle t
  task automatic push_exp(input int i, input int t, input bit dec, input bit kn);
    int   nr, n;
    bit   eff_kn, skip, kl;
    exp_t x;
    nr     = NR_TAB[i];
    eff_kn = kn;
`ifndef AES_KEY_CACHE_EN
    eff_kn = 1'b1;
`endif
    skip = dec && !eff_kn && cv_m[i] && (kpos_m[i] == nr);
    kl   = !dec || eff_kn || !cv_m[i];
    n    = 0;
    if (dec && !skip)
      for (int k = 0; k < nr; k++) begin
        rec_q[i].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, k));
        n++;
      end
    rec_q[i].push_back(mk(1'b0, 1'b1, dec, 1'b1, 2'b00, dec ? nr : 0));
    n++;
    for (int j = 1; j < nr; j++) begin
      rec_q[i].push_back(mk(1'b0, 1'b1, dec, 1'b1, 2'b01, dec ? nr - j : j));
      n++;
    end
    rec_q[i].push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, dec ? 0 : nr));
    rec_q[i].push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, dec ? 0 : nr));
    n += 2;
    x.t_acc  = t;
    x.t_done = t + n;
    x.inv    = dec;
    x.kl     = kl;
    x.len    = n;
    exp_q[i].push_back(x);
    cv_m[i]   = 1'b1;
    kpos_m[i] = dec ? 0 : nr;
  endtask

  task automatic op(input int i, input bit dec, input bit kn);
    @(posedge clk); #1;
    start[i]   = 1'b1;
    decrypt[i] = dec;
`ifdef AES_KEY_CACHE_EN
    key_new[i] = kn;
`endif
    push_exp(i, cyc, dec, kn);
    @(posedge clk); #1;
    start[i]   = 1'b0;
    decrypt[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    int k;
    k = 0;
    while (exp_q[i].size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    n_total++;
    if (exp_q[i].size() == 0) n_pass++;
    else $display("FAIL inst%0d drain_timeout: got %0d ops outstanding, required 0", i, exp_q[i].size());
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      cv_m[i]   = 1'b0;
      kpos_m[i] = 0;
    end
  endtask

  initial begin
    int t0;
    reset   = 1'b0;
    start   = '0;
    decrypt = '0;
`ifdef AES_KEY_CACHE_EN
    key_new = '0;
`endif
    model_reset();
    #23;
    for (int i = 0; i < NI; i++) check(i, "reset_outputs", outs(i), 0);
    @(negedge clk);
    reset = 1'b1;

    // K=128 encrypt, then decrypt reusing the key, then decrypt with new key
    op(0, 1'b0, 1'b1); wait_drain(0);
    op(0, 1'b1, 1'b0); wait_drain(0);
    op(0, 1'b1, 1'b1); wait_drain(0);

    // K=256 encrypt, K=192 decrypt
    op(2, 1'b0, 1'b1); wait_drain(2);
    op(1, 1'b1, 1'b1); wait_drain(1);

    // Starts while busy and in the DONE cycle are ignored; next one accepted
    @(posedge clk); #1;
    t0 = cyc;
    start[0] = 1'b1; decrypt[0] = 1'b0;
`ifdef AES_KEY_CACHE_EN
    key_new[0] = 1'b1;
`endif
    push_exp(0, t0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b1; decrypt[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; decrypt[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    push_exp(0, cyc, 1'b0, 1'b1);
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_drain(0);

    // Asynchronous reset in the middle of ROUND, then a fresh decrypt
    op(0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check(0, "pre_reset_rk_idx", int'(rk_idx[0]), 5);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) check(i, "async_reset_outputs", outs(i), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    op(0, 1'b1, 1'b1); wait_drain(0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Round sequencer for the iterative AES encrypt/decrypt core behind the SPI front end. Accepts a start/direction request once the frame (block, key, direction byte) has been shifted in. Drives state-register, round-select and key-schedule controls for Nr rounds, then pulses done so the front end can shift the 128-bit result out. Contains no datapath; it only issues controls.

Parameters:
K, 256, key length in bits; legal values 128/192/256, anything else is an elaboration error
NR, K/32+6, round count (10/12/14); derived, not overridable

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; accepted only in IDLE
decrypt  in  1  direction, sampled on start acceptance (1 = inverse cipher)
busy  out  1  high from the acceptance cycle+1 through DONE
done  out  1  one-cycle pulse; result valid in the datapath
key_load  out  1  load cipher key into the key register (acceptance cycle)
key_step  out  1  advance the key schedule one round key
key_rev  out  1  step direction: 0 forward, 1 inverse schedule
rk_idx  out  4  index of the round key currently in the key register
st_en  out  1  state register update enable
rnd_sel  out  2  00 initial AddRoundKey, 01 full round, 10 final round (no (Inv)MixColumns)
inv  out  1  registered decrypt, held from acceptance until the next acceptance

Behaviour:
- Reset (async, any state): state IDLE; every output 0; round counter 0.
- IDLE: start=1 -> key_load=1 in the same cycle, inv latched; next state KEYEXP if decrypt, else INIT. start=0 -> stay.
- KEYEXP (decrypt only): NR cycles. key_step=1, key_rev=0, st_en=0. rk_idx = 0..NR-1, reaching NR on exit. Next: INIT.
- INIT: 1 cycle. rnd_sel=00, st_en=1, key_step=1. Enc: rk_idx=0, key_rev=0. Dec: rk_idx=NR, key_rev=1.
- ROUND: NR-1 cycles. rnd_sel=01, st_en=1, key_step=1. rk_idx: enc 1..NR-1, dec NR-1..1.
- FINAL: 1 cycle. rnd_sel=10, st_en=1, key_step=0. rk_idx: enc NR, dec 0.
- DONE: done=1 for 1 cycle, busy=1; next IDLE. rk_idx holds its final value.
- Latency from the acceptance cycle to done: enc NR+2 cycles; dec 2*NR+2 cycles.
- start while busy is ignored and not queued. start in the DONE cycle is ignored; the earliest re-accept is the cycle after done.
- The round counter is 4 bits, up/down; it must never wrap. Exit conditions compare against NR and 0 exactly.
- rk_idx, rnd_sel, st_en, key_* and done are Moore outputs (registered state decode), except key_load, which is combinational from IDLE & start.

Optional Feature:
AES_KEY_CACHE_EN
- With: extra input key_new (1 bit, sampled with start) and an internal cache_valid flag (reset 0) plus key position.
  - key_load fires only if key_new=1 or cache_valid=0.
  - Decrypt with key_new=0, cache_valid=1 and key register at rk NR (the previous op was an encrypt) skips KEYEXP. Latency is then NR+2.
  - Encrypt always issues key_load.
  - cache_valid is set at DONE and cleared by reset.
- Without: key_new port absent; every request behaves as key_new=1.

Decomposition:
- aes_pkg: rnd_sel_t enum (RND_INIT, RND_FULL, RND_FINAL), ctrl state enum (IDLE, KEYEXP, INIT, ROUND, FINAL, DONE), function nr_of(K).
- Sub-module aes_round_cnt: 4-bit loadable up/down counter with load value, dir, en, and at_zero/at_nr flags. Instantiated once.

Test Plan:
- K=128, start with decrypt=0 at cycle t -> key_load at t; rk_idx 0,1..9,10 on t+1..t+11; rnd_sel 00,01x9,10; done only at t+12.
- K=128, decrypt=1 -> KEYEXP rk_idx 0..9 with key_rev=0 on t+1..t+10; then rk_idx 10..0 with key_rev=1; done at t+22; inv=1.
- K=256 encrypt -> 14 st_en cycles after INIT; done at t+16. K=192 decrypt -> done at t+26.
- start pulsed at t+3 and in the DONE cycle of a running encrypt -> no effect; the next start after done is accepted normally.
- reset asserted during ROUND (rk_idx=5) -> all outputs 0 asynchronously; after release, a start gives a full fresh sequence.
- AES_KEY_CACHE_EN: encrypt key_new=1, then decrypt key_new=0 -> no key_load, no KEYEXP, done at t+12. Same sequence with the macro off -> done at t+22.
